// File: rtl/proc_pkg.sv
// ---------------------------------------------------------------------------
// proc_pkg : request-line sizes and vector types shared with req_encoder_five
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package proc_pkg;

  localparam int REQ_N     = 32;
  localparam int REQ_IDX_W = 5;

  typedef logic [REQ_N-1:0]     req_vec_t;
  typedef logic [REQ_IDX_W-1:0] req_idx_t;

endpackage

`default_nettype wire

// File: rtl/req_encoder_five_find_first_set.sv
// ---------------------------------------------------------------------------
// find_first_set : first set bit of a vector, searching upward from start_i
//                  and wrapping from N-1 back to 0 (combinational)
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module find_first_set #(
  parameter int N = 32,
  parameter int W = 5
) (
  input  logic [N-1:0] vec_i,
  input  logic [W-1:0] start_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  function automatic logic [W-1:0] wrap_add(input logic [W-1:0] a, input int b);
    logic [W:0] s;
    s = {1'b0, a} + (W+1)'(b);
    if (s >= (W+1)'(N)) s = s - (W+1)'(N);
    return s[W-1:0];
  endfunction

  // Scan from the far end so the hit closest to start_i is written last.
  always_comb begin
    found_o = |vec_i;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[wrap_add(start_i, i)]) idx_o = wrap_add(start_i, i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/req_encoder_five.sv
// ---------------------------------------------------------------------------
// req_encoder_five : sticky 32-to-5 request encoder with valid/ready output.
//                    Define REQ_ENCODER_RR_EN for round-robin selection;
//                    the default build uses fixed lowest-index priority.
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module req_encoder_five
  import proc_pkg::*;
#(
  parameter int N_REQ = REQ_N,
  parameter int IDX_W = REQ_IDX_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req_in,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [N_REQ-1:0] pending,
  output logic             busy
);

  logic [N_REQ-1:0] pending_q, pending_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] sel;
  logic             found;
  logic             load;
  logic             take;
  logic [N_REQ-1:0] clr_mask;

  assign load = !valid_q || out_ready;
  assign take = load && found;

`ifdef REQ_ENCODER_RR_EN
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  logic [IDX_W-1:0] last_idx_q, last_idx_d;

  assign start = (last_idx_q == LAST_RST) ? '0 : last_idx_q + IDX_W'(1);

  always_comb begin
    last_idx_d = last_idx_q;
    if (!flush && take) last_idx_d = sel;
  end

  always_ff @(posedge clock) begin
    if (reset) last_idx_q <= LAST_RST;
    else       last_idx_q <= last_idx_d;
  end
`else
  assign start = '0;
`endif

  find_first_set #(
    .N (N_REQ),
    .W (IDX_W)
  ) u_ffs (
    .vec_i   (pending_q),
    .start_i (start),
    .found_o (found),
    .idx_o   (sel)
  );

  assign clr_mask = take ? (N_REQ'(1) << sel) : '0;

  // A pulse on the line being granted re-arms it as a fresh event.
  always_comb begin
    pending_d = (pending_q & ~clr_mask) | req_in;
    valid_d   = load ? found : valid_q;
    idx_d     = take ? sel : idx_q;
    if (flush) begin
      pending_d = '0;
      valid_d   = 1'b0;
      idx_d     = idx_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign pending   = pending_q;
  assign busy      = (|pending_q) | valid_q;

endmodule

`default_nettype wire

// File: tb/tb_req_encoder_five.sv
// ---------------------------------------------------------------------------
// tb_req_encoder_five : directed vector table plus an all-lines drain sequence
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_req_encoder_five;

`ifdef REQ_ENCODER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] req_in = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [4:0]  out_idx;
  logic [31:0] pending;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  req_encoder_five dut (
    .clock     (clock),
    .reset     (reset),
    .req_in    (req_in),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .pending   (pending),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        fl;
    logic [31:0] req;
    logic        rdy;
    logic        ev;
    logic [4:0]  ei;
    logic [31:0] ep;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic f, input logic [31:0] rq,
                              input logic rd, input logic ev, input logic [4:0] ei,
                              input logic [31:0] ep);
    vecs.push_back('{rst: r, fl: f, req: rq, rdy: rd, ev: ev, ei: ei, ep: ep});
  endfunction

  task automatic chk(input string nm, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", nm, step, act, exp);
  endtask

  task automatic drive(input logic r, input logic f, input logic [31:0] rq, input logic rd);
    reset     = r;
    flush     = f;
    req_in    = rq;
    out_ready = rd;
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input int step, input logic ev, input logic [4:0] ei,
                           input logic [31:0] ep);
    chk("out_valid", step, {31'b0, out_valid}, {31'b0, ev});
    chk("out_idx",   step, {27'b0, out_idx},   {27'b0, ei});
    chk("pending",   step, pending,            ep);
    chk("busy",      step, {31'b0, busy},      {31'b0, (|ep) | ev});
  endtask

  initial begin
    logic [31:0] full;
    int          step;

    // reset and idle
    add(1, 0, 32'h0,         0, 0, 0,  32'h0);
    add(1, 0, 32'h0,         0, 0, 0,  32'h0);
    add(0, 0, 32'h0,         0, 0, 0,  32'h0);
    add(0, 0, 32'h0,         1, 0, 0,  32'h0);
    // single request, two-edge latency
    add(0, 0, 32'h0000_0100, 1, 0, 0,  32'h0000_0100);
    add(0, 0, 32'h0,         1, 1, 8,  32'h0);
    add(0, 0, 32'h0,         1, 0, 8,  32'h0);
    // backpressure, starting from reset
    add(1, 0, 32'h0,         0, 0, 0,  32'h0);
    add(0, 0, 32'h8000_0003, 0, 0, 0,  32'h8000_0003);
    for (int i = 0; i < 5; i++) add(0, 0, 32'h0, 0, 1, 0, 32'h8000_0002);
    add(0, 0, 32'h0,         1, 1, 1,  32'h8000_0000);
    add(0, 0, 32'h0,         1, 1, 31, 32'h0);
    add(0, 0, 32'h0,         1, 0, 31, 32'h0);
    // re-arm collision on line 5
    add(0, 0, 32'h0000_0020, 0, 0, 31, 32'h0000_0020);
    add(0, 0, 32'h0000_0020, 0, 1, 5,  32'h0000_0020);
    add(0, 0, 32'h0,         1, 1, 5,  32'h0);
    add(0, 0, 32'h0,         1, 0, 5,  32'h0);
    // continuous requests on lines 0 and 4
    add(0, 0, 32'h0000_0011, 1, 0, 5,  32'h0000_0011);
    add(0, 0, 32'h0000_0011, 1, 1, 0,  32'h0000_0011);
    add(0, 0, 32'h0000_0011, 1, 1, RR ? 5'd4 : 5'd0, 32'h0000_0011);
    add(0, 0, 32'h0000_0011, 1, 1, 0,  32'h0000_0011);
    add(0, 0, 32'h0000_0011, 1, 1, RR ? 5'd4 : 5'd0, 32'h0000_0011);
    add(0, 0, 32'h0,         1, 1, 0,  32'h0000_0010);
    add(0, 0, 32'h0,         1, 1, 4,  32'h0);
    add(0, 0, 32'h0,         1, 0, 4,  32'h0);
    // flush mid-transfer; same-cycle request is dropped
    add(0, 0, 32'hFFFF_FFFF, 0, 0, 4,  32'hFFFF_FFFF);
    add(0, 0, 32'h0,         0, 1, RR ? 5'd5 : 5'd0, RR ? 32'hFFFF_FFDF : 32'hFFFF_FFFE);
    add(0, 1, 32'h0000_0001, 0, 0, RR ? 5'd5 : 5'd0, 32'h0);
    add(0, 0, 32'h0,         0, 0, RR ? 5'd5 : 5'd0, 32'h0);
    // reset mid-transfer
    add(0, 0, 32'hFFFF_FFFF, 0, 0, RR ? 5'd5 : 5'd0, 32'hFFFF_FFFF);
    add(0, 0, 32'h0,         0, 1, RR ? 5'd6 : 5'd0, RR ? 32'hFFFF_FFBF : 32'hFFFF_FFFE);
    add(1, 0, 32'h0000_0001, 0, 0, 0,  32'h0);
    add(0, 0, 32'h0,         0, 0, 0,  32'h0);

    #1;
    step = 0;
    foreach (vecs[n]) begin
      drive(vecs[n].rst, vecs[n].fl, vecs[n].req, vecs[n].rdy);
      check_all(step, vecs[n].ev, vecs[n].ei, vecs[n].ep);
      step++;
    end

    // all lines pending after reset: 32 back-to-back grants in index order
    full = 32'hFFFF_FFFF;
    drive(0, 0, 32'hFFFF_FFFF, 1);
    check_all(step, 0, 0, 32'hFFFF_FFFF);
    step++;
    for (int k = 0; k < 32; k++) begin
      drive(0, 0, 32'h0, 1);
      check_all(step, 1, 5'(k), full << (k + 1));
      step++;
    end
    drive(0, 0, 32'h0, 1);
    check_all(step, 0, 31, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/req_encoder_five.md
Name: req_encoder_five

Overview:
- Sequential 32-to-5 request encoder, the inverse of the team's 5-to-32 one-hot decoder.
- Collects single-cycle request pulses on 32 lines into sticky pending bits.
- Emits each pending line as a 5-bit index through a registered valid/ready output, one index per accepted transfer.
- Used for interrupt/exception cause encoding and for writeback-select compression in the processor.

Parameters:
N_REQ, 32, number of request lines.
IDX_W, 5, index width; must equal log2(N_REQ).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
req_in  input  N_REQ  request pulses; bit k high for one cycle sets pending[k].
flush  input  1  synchronous clear of all pending bits and the output register.
out_ready  input  1  consumer accepts out_idx when out_valid is also high.
out_valid  output  1  out_idx holds a valid index.
out_idx  output  IDX_W  index of the granted request line.
pending  output  N_REQ  current sticky pending vector, for debug and status.
busy  output  1  equals (|pending) | out_valid.

Behaviour:
- Reset: synchronous; clock and reset are one clock, active-high synchronous reset.
  - At an edge with reset high: pending=0, out_valid=0, out_idx=0, internal last_idx=N_REQ-1.
  - Reset overrides flush and req_in. A reset mid-transfer drops the presented index without any handshake.
- Flush: at an edge with flush high and reset low, pending=0 and out_valid=0. out_idx holds its value. req_in in the same cycle is discarded.
- Load condition: load = !out_valid || out_ready.
- Selection: sel = first set bit of pending in search order (see Optional Feature). found = |pending.
- Output register, at an edge with load high:
  - out_valid <= found.
  - If found: out_idx <= sel and last_idx <= sel. Otherwise out_idx holds.
- Pending update: pending_next = (pending & ~clr_mask) | req_in, where clr_mask = onehot(sel) if (load && found), else 0.
  - A req_in pulse on the same line being loaded re-arms that bit. It is a new event and is not lost.
- Selection uses registered pending only, never req_in.
  - Latency: req_in pulse at edge N sets pending after N; out_valid is high after edge N+1 if the output was free.
- Handshake:
  - While out_valid && !out_ready, out_idx and out_valid stay stable.
  - Back-to-back transfers run every cycle when out_ready is held high and pending is non-empty (throughput 1/cycle).
- Repeated pulses on an already-pending line merge into one event (no counting).
- All N_REQ lines pending: the output drains over 32 accepted transfers. No overflow condition exists.

Optional Feature:
- Macro: REQ_ENCODER_RR_EN.
- Defined: round-robin. The search starts at (last_idx+1) mod N_REQ and wraps at N_REQ-1→0. last_idx updates on each load with found.
- Undefined: fixed priority. The lowest set index wins. last_idx is not implemented, and its reset is irrelevant.

Decomposition:
- Shared package proc_pkg:
  - REQ_N=32 and REQ_IDX_W=5.
  - typedefs req_vec_t [31:0] and req_idx_t [4:0].
- One natural sub-module: find_first_set (combinational). Inputs are a vector and a start index; outputs are found and index.
  - Fixed-priority mode ties the start index to 0.
  - Instantiated once.

Test Plan:
- Reset/idle: reset high 2 cycles → out_valid=0, out_idx=0, pending=0, busy=0. Then reset low with no requests → all remain 0.
- Single request: req_in=0x0000_0100 for 1 cycle with out_ready=1 → out_valid=1, out_idx=8 exactly two edges after the pulse. The following cycle out_valid=0 and pending=0.
- Backpressure: req_in=0x8000_0003 with out_ready=0 → out_idx=0 and stays stable for 5 cycles. Raising out_ready yields indices 0,1,31 on consecutive cycles (fixed) or 0,1,31 (RR from reset).
- Re-arm collision: with pending[5] about to load, pulse req_in[5] in that cycle → two transfers of index 5 are observed.
- Round-robin (REQ_ENCODER_RR_EN): hold req_in=0x0000_0011 every cycle with out_ready=1 → out_idx alternates 0,4,0,4. Without the macro it is 0,0,0 whenever bit 0 is re-armed.
- Flush/reset mid-operation: pending=0xFFFF_FFFF, out_valid=1, out_ready=0, then flush pulse → out_valid=0, pending=0 next cycle. Repeat with reset instead → same result plus out_idx=0.
